// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer.
// Pulses the panel hardware reset, waits for the panel to settle, then walks
// a command ROM. Each ROM word is either a byte for the serial transmitter or
// a delay. A delay of zero is the end marker.
module ili9341_init_seq #(
    parameter int RST_LOW_CYCLES  = 160000,
    parameter int RST_WAIT_CYCLES = 1920000,
    parameter int DELAY_UNIT      = 16000,
    parameter int ADDR_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 lcd_rst_n,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [9:0]           rom_data,
    output logic                 tx_valid,
    output logic                 tx_dc,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_LOW  = 3'd1;
    localparam logic [2:0] S_RST_WAIT = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_DECODE   = 3'd4;
    localparam logic [2:0] S_SEND     = 3'd5;
    localparam logic [2:0] S_DELAY    = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // Delay product: 8-bit payload times DELAY_UNIT, one spare bit so it never overflows.
    localparam int PROD_W = 8 + $clog2(DELAY_UNIT) + 1;
    localparam int RL_W   = $clog2(RST_LOW_CYCLES + 1);
    localparam int RW_W   = $clog2(RST_WAIT_CYCLES + 1);
    localparam int MAX_RW = (RL_W > RW_W) ? RL_W : RW_W;
    localparam int CNT_W  = (MAX_RW > PROD_W) ? MAX_RW : PROD_W;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
    logic                 tx_dc_q, tx_dc_d;
    logic [7:0]           tx_data_q, tx_data_d;

    logic                 addr_last;
    logic                 cnt_zero;
    logic [PROD_W-1:0]    delay_prod;

    assign addr_last  = &rom_addr_q;
    assign cnt_zero   = (cnt_q == '0);
    assign delay_prod = PROD_W'(rom_data[7:0]) * PROD_W'(DELAY_UNIT) - PROD_W'(1);

    // Next-state, counter, ROM address and transmit byte computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        tx_dc_d    = tx_dc_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RST_LOW;
                    cnt_d   = CNT_W'(RST_LOW_CYCLES - 1);
                end
            end
            S_RST_LOW: begin
                if (cnt_zero) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = CNT_W'(RST_WAIT_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RST_WAIT: begin
                if (cnt_zero) begin
                    state_d    = S_FETCH;
                    rom_addr_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!rom_data[9]) begin
                    tx_dc_d   = rom_data[8];
                    tx_data_d = rom_data[7:0];
                    state_d   = S_SEND;
                end else if (rom_data[7:0] == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(delay_prod);
                    state_d = S_DELAY;
                end
            end
            S_SEND: begin
                // Last address without an end marker finishes instead of wrapping to 0.
                if (tx_ready) begin
                    if (addr_last) begin
                        state_d = S_DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_BITS'(1);
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_zero) begin
                    if (addr_last) begin
                        state_d = S_DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_BITS'(1);
                        state_d    = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            tx_dc_q    <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            tx_dc_q    <= tx_dc_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign lcd_rst_n = (state_q != S_RST_LOW);
    assign tx_valid  = (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign rom_addr  = rom_addr_q;
    assign tx_dc     = tx_dc_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_ili9341_init_seq.sv
// Bench for ili9341_init_seq: directed programs plus random ROM programs,
// checked by a scoreboard fed from a ROM-walking reference model.
module tb_ili9341_init_seq;

    localparam int RL    = 4;
    localparam int RW    = 8;
    localparam int DU    = 2;
    localparam int AB    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          lcd_rst_n;
    logic [AB-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic          tx_valid;
    logic          tx_dc;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          busy;
    logic          done;

    ili9341_init_seq #(
        .RST_LOW_CYCLES (RL),
        .RST_WAIT_CYCLES(RW),
        .DELAY_UNIT     (DU),
        .ADDR_BITS      (AB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .lcd_rst_n(lcd_rst_n),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tx_valid (tx_valid),
        .tx_dc    (tx_dc),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    logic [9:0] rom [DEPTH];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: expected bytes with the number of idle samples before each one.
    typedef struct {
        int dc;
        int data;
        int gap;
    } exp_t;
    exp_t exp_q[$];
    int   exp_done_gap   = 0;
    int   exp_first_hold = -1;

    // Reference model: walk the ROM as a program and derive bytes and timing.
    task automatic build_model();
        int acc;
        exp_t e;
        exp_q.delete();
        acc = RW;
        for (int a = 0; a < DEPTH; a++) begin
            if (rom[a][9]) begin
                if (rom[a][7:0] == 8'd0) begin
                    acc += 2;
                    break;
                end
                acc += 2 + int'(rom[a][7:0]) * DU;
            end else begin
                e.dc   = int'(rom[a][8]);
                e.data = int'(rom[a][7:0]);
                e.gap  = acc + 2;
                exp_q.push_back(e);
                acc = 0;
            end
        end
        exp_done_gap = acc;
    endtask

    // tx_ready driver: 0 always ready, 1 random, 2 stall first byte 7 cycles, 3 never ready.
    int rdy_mode  = 0;
    int stall_cnt = 0;
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (tx_valid && stall_cnt < 7) begin
                        tx_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples on the falling edge and compares against the scoreboard.
    initial begin
        int   gap_cnt, low_cnt, hold_len, byte_idx, paddr;
        logic pv, pacc, plcd, pdone, pdc;
        logic [7:0] pdata;
        exp_t e;
        gap_cnt = 0; low_cnt = 0; hold_len = 0; byte_idx = 0; paddr = 0;
        pv = 0; pacc = 0; plcd = 1; pdone = 0; pdc = 0; pdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap_cnt = 0; low_cnt = 0; hold_len = 0; byte_idx = 0; paddr = 0;
                pv = 0; pacc = 0; plcd = 1; pdone = 0;
            end else begin
                if (tx_valid) begin
                    if (pv && !pacc) begin
                        chk("hold_dc", int'(tx_dc), int'(pdc));
                        chk("hold_data", int'(tx_data), int'(pdata));
                        hold_len++;
                    end else begin
                        hold_len = 1;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_byte: got dc=%0d data=0x%02h expected none", tx_dc, tx_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("byte_dc", int'(tx_dc), e.dc);
                            chk("byte_data", int'(tx_data), e.data);
                            chk("byte_gap", gap_cnt, e.gap);
                        end
                        byte_idx++;
                    end
                    if (tx_ready && exp_first_hold >= 0 && byte_idx == 1)
                        chk("first_hold", hold_len, exp_first_hold);
                end
                if (done && !pdone) chk("done_gap", gap_cnt, exp_done_gap);
                if (lcd_rst_n && !plcd) chk("rst_low_len", low_cnt, RL);
                low_cnt = lcd_rst_n ? 0 : low_cnt + 1;
                if (int'(rom_addr) != paddr) chk("addr_step", int'(rom_addr), paddr + 1);
                gap_cnt = (!lcd_rst_n || (tx_valid && tx_ready)) ? 0 : gap_cnt + 1;
                pv    = tx_valid;
                pacc  = tx_valid && tx_ready;
                pdc   = tx_dc;
                pdata = tx_data;
                plcd  = lcd_rst_n;
                pdone = done;
                paddr = int'(rom_addr);
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_lcd_rst_n"}, int'(lcd_rst_n), 1);
        chk({tag, "_tx_valid"}, int'(tx_valid), 0);
        chk({tag, "_tx_dc"}, int'(tx_dc), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic run_prog(input int mode, input int first_hold);
        int n;
        build_model();
        exp_first_hold = first_hold;
        rdy_mode       = mode;
        stall_cnt      = 0;
        pulse_start();
        n = 0;
        while (!done && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", n);
        end
        @(negedge clk);
        #1;
        chk("bytes_left", exp_q.size(), 0);
        chk("end_done", int'(done), 1);
        chk("end_busy", int'(busy), 0);
        // start is ignored once finished
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", int'(done), 1);
        chk("done_not_busy", int'(busy), 0);
        chk("done_lcd_rst_n", int'(lcd_rst_n), 1);
        start = 1'b0;
        exp_first_hold = -1;
    endtask

    task automatic load4(input logic [9:0] w0, input logic [9:0] w1,
                         input logic [9:0] w2, input logic [9:0] w3);
        for (int a = 0; a < DEPTH; a++) rom[a] = 10'h200;
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        for (int a = 0; a < DEPTH; a++) rom[a] = 10'h200;
        #1 check_reset_outputs("por");
        #20;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // no state change without start
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_lcd_rst_n", int'(lcd_rst_n), 1);

        // SLPOUT then end
        load4(10'h011, 10'h200, 10'h200, 10'h200);
        run_prog(0, -1);
        apply_reset();

        // command with two data bytes
        load4(10'h02A, 10'h100, 10'h1EF, 10'h200);
        run_prog(0, -1);
        apply_reset();

        // delay of 5 units between SLPOUT and DISPON
        load4(10'h011, 10'h205, 10'h029, 10'h200);
        run_prog(0, -1);
        apply_reset();

        // first byte stalled 7 cycles
        load4(10'h02A, 10'h100, 10'h200, 10'h200);
        run_prog(2, 8);
        apply_reset();

        // no end marker: all eight addresses sent, no wrap
        for (int a = 0; a < DEPTH; a++) rom[a] = 10'h000;
        run_prog(0, -1);
        apply_reset();

        // reset while a byte is held in SEND
        load4(10'h02A, 10'h100, 10'h1EF, 10'h200);
        build_model();
        rdy_mode = 3;
        pulse_start();
        n = 0;
        while (!tx_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_reached_send", int'(tx_valid), 1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        run_prog(0, -1);
        apply_reset();

        // random programs with random back-pressure
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 6 || r == 7)
                    rom[a] = {2'b10, 8'($urandom_range(1, 6))};
                else if (r == 8)
                    rom[a] = 10'h200;
                else
                    rom[a] = {1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
            end
            run_prog(1, -1);
            apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
